// File: rtl/collision_matrix_if.sv
// Collision event stream from the detector FIFO head to the game controller.
// The master side presents the head entry and occupancy; the slave side accepts it with ev_ready.
interface collision_matrix_if #(
   parameter int NUM_BALLS   = 2,
   parameter int NUM_TARGETS = 8,
   parameter int FIFO_DEPTH  = 8
);
   localparam int BW = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
   localparam int TW = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic          ev_valid;
   logic          ev_ready;
   logic [BW-1:0] ev_ball;
   logic [TW-1:0] ev_target;
   logic [CW-1:0] ev_count;

   modport master (output ev_valid, ev_ball, ev_target, ev_count, input ev_ready);
   modport slave  (input ev_valid, ev_ball, ev_target, ev_count, output ev_ready);
endinterface

// File: rtl/collision_matrix.sv
// Multi-ball / multi-target collision detector: per-pair once-per-frame and cooldown
// filtering, registered hit pulses, and a first-word-fall-through event FIFO.
module collision_matrix #(
   parameter int NUM_BALLS       = 2,
   parameter int NUM_TARGETS     = 8,
   parameter int COOLDOWN_FRAMES = 2,
   parameter int FIFO_DEPTH      = 8
) (
   input  logic                             clk,
   input  logic                             resetN,
   input  logic                             startOfFrame,
   input  logic [NUM_BALLS-1:0]             draw_ball,
   input  logic [NUM_TARGETS-1:0]           draw_target,
   input  logic [NUM_TARGETS-1:0]           target_en,
   input  logic                             freeze,
   output logic [NUM_BALLS*NUM_TARGETS-1:0] collision_pulse,
   output logic                             overflow,
   collision_matrix_if.master               ev
);
   localparam int NP = NUM_BALLS * NUM_TARGETS;
   localparam int BW = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
   localparam int TW = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = BW + TW;
   localparam logic [3:0] COOL = 4'(COOLDOWN_FRAMES);

   logic [NP-1:0] hit;
   logic [NP-1:0] seen_q, seen_d, pend_q, pend_d, pulse_q, pulse_d;
   logic [3:0]    cool_q [NP];
   logic [3:0]    cool_d [NP];
   logic          ovf_q, ovf_d;

   logic [EW-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          found, push, pop;
   logic [NP-1:0] gnt;
   logic [EW-1:0] gnt_ev;

   always_comb begin
      hit = '0;
      for (int unsigned b = 0; b < NUM_BALLS; b++)
         for (int unsigned t = 0; t < NUM_TARGETS; t++)
            hit[b*NUM_TARGETS+t] = draw_ball[b] & draw_target[t] & target_en[t] & ~freeze;
   end

   // Fixed-priority arbiter: lowest pair index wins one FIFO slot per cycle.
   always_comb begin
      found  = 1'b0;
      gnt    = '0;
      gnt_ev = '0;
      for (int unsigned b = 0; b < NUM_BALLS; b++)
         for (int unsigned t = 0; t < NUM_TARGETS; t++)
            if (!found && pend_q[b*NUM_TARGETS+t]) begin
               found                 = 1'b1;
               gnt[b*NUM_TARGETS+t]  = 1'b1;
               gnt_ev                = {BW'(b), TW'(t)};
            end
      pop  = (cnt_q != '0) && ev.ev_ready;
      push = found && ((cnt_q != CW'(FIFO_DEPTH)) || pop);
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_comb begin
      pulse_d = '0;
      ovf_d   = ovf_q;
      seen_d  = seen_q;
      cool_d  = cool_q;
      pend_d  = push ? (pend_q & ~gnt) : pend_q;
      for (int unsigned p = 0; p < NP; p++) begin
         // The frame boundary that closes the hit frame does not count toward cooldown,
         // so COOLDOWN_FRAMES whole frames after the hit stay suppressed.
         if (startOfFrame) begin
            seen_d[p] = 1'b0;
            if (!seen_q[p] && cool_q[p] != '0)
               cool_d[p] = cool_q[p] - 4'd1;
         end
         if (hit[p] && !seen_d[p] && cool_d[p] == '0) begin
            seen_d[p]  = 1'b1;
            cool_d[p]  = COOL;
            pulse_d[p] = 1'b1;
            if (pend_d[p]) ovf_d     = 1'b1;
            else           pend_d[p] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge resetN) begin
      if (resetN) begin
         seen_q  <= '0;
         pend_q  <= '0;
         pulse_q <= '0;
         ovf_q   <= 1'b0;
         for (int unsigned i = 0; i < NP; i++) cool_q[i] <= '0;
      end else begin
         seen_q  <= seen_d;
         pend_q  <= pend_d;
         pulse_q <= pulse_d;
         ovf_q   <= ovf_d;
         cool_q  <= cool_d;
      end
   end

   always_ff @(posedge clk or posedge resetN) begin
      if (resetN) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (push) begin
            mem_q[wr_q] <= gnt_ev;
            wr_q        <= wr_q + AW'(1);
         end
         if (pop) rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_d;
      end
   end

   assign ev.ev_valid      = (cnt_q != '0);
   assign ev.ev_ball       = mem_q[rd_q][EW-1:TW];
   assign ev.ev_target     = mem_q[rd_q][TW-1:0];
   assign ev.ev_count      = cnt_q;
   assign collision_pulse  = pulse_q;
   assign overflow         = ovf_q;
endmodule

// File: tb/tb_collision_matrix.sv
// Directed bench for collision_matrix with an event scoreboard checked on every FIFO pop.
module tb_collision_matrix;
   logic        clk = 1'b0;
   logic        resetN, sof, freeze;
   logic [1:0]  db;
   logic [7:0]  dt, en;
   logic [15:0] pulse;
   logic        ovf;

   int          total = 0;
   int          bad   = 0;
   logic [3:0]  sb [$];
   int          pcnt [16];

   collision_matrix_if #(.NUM_BALLS(2), .NUM_TARGETS(8), .FIFO_DEPTH(8)) bus ();

   collision_matrix #(
      .NUM_BALLS(2), .NUM_TARGETS(8), .COOLDOWN_FRAMES(2), .FIFO_DEPTH(8)
   ) dut (
      .clk(clk), .resetN(resetN), .startOfFrame(sof), .draw_ball(db), .draw_target(dt),
      .target_en(en), .freeze(freeze), .collision_pulse(pulse), .overflow(ovf), .ev(bus.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pops the scoreboard on a handshake, then advances one clock and samples 1ns later.
   task automatic tick();
      logic [31:0] exp;
      if (bus.ev_valid === 1'b1 && bus.ev_ready) begin
         exp = '1;
         if (sb.size() != 0) exp = 32'(sb.pop_front());
         chk("ev_pair", 32'({bus.ev_ball, bus.ev_target}), exp);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 16; i++) if (pulse[i] === 1'b1) pcnt[i]++;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic px(input logic s, input logic [1:0] b, input logic [7:0] t);
      sof = s; db = b; dt = t;
      tick();
      sof = 1'b0; db = '0; dt = '0;
   endtask

   task automatic chk_reset_state();
      chk("rst_pulse", 32'(pulse), 32'h0);
      chk("rst_valid", 32'(bus.ev_valid), 32'h0);
      chk("rst_ball", 32'(bus.ev_ball), 32'h0);
      chk("rst_target", 32'(bus.ev_target), 32'h0);
      chk("rst_count", 32'(bus.ev_count), 32'h0);
      chk("rst_ovf", 32'(ovf), 32'h0);
   endtask

   initial begin
      resetN = 1'b1; sof = 1'b0; freeze = 1'b0; db = '0; dt = '0; en = 8'hFF;
      bus.ev_ready = 1'b0;
      foreach (pcnt[i]) pcnt[i] = 0;
      #1;
      idle(2);
      chk_reset_state();
      resetN = 1'b0;
      tick();

      // single hit: ball 0 / target 3 for 20 pixels
      bus.ev_ready = 1'b1;
      px(1'b1, 2'b00, 8'h00);
      foreach (pcnt[i]) pcnt[i] = 0;
      sb.push_back({1'b0, 3'd3});
      px(1'b0, 2'b01, 8'h08);
      chk("single_pulse", 32'(pulse), 32'h0008);
      px(1'b0, 2'b01, 8'h08);
      chk("single_valid", 32'(bus.ev_valid), 32'h1);
      repeat (18) px(1'b0, 2'b01, 8'h08);
      idle(3);
      chk("single_pcnt", 32'(pcnt[3]), 32'd1);
      chk("single_sb", 32'(sb.size()), 32'd0);
      chk("single_count", 32'(bus.ev_count), 32'd0);

      // cooldown: pair (1,6) overlapping in four consecutive frames
      pcnt[14] = 0;
      for (int f = 0; f < 4; f++) begin
         if (f == 0 || f == 3) sb.push_back({1'b1, 3'd6});
         if (f == 3) begin
            px(1'b1, 2'b10, 8'h40);
            chk("cool_sof_pulse", 32'(pulse), 32'h4000);
         end else begin
            px(1'b1, 2'b00, 8'h00);
         end
         repeat (3) px(1'b0, 2'b10, 8'h40);
         idle(2);
         chk("cool_pcnt", 32'(pcnt[14]), (f >= 3) ? 32'd2 : 32'd1);
      end
      chk("cool_sb", 32'(sb.size()), 32'd0);

      // simultaneous: (0,2),(1,5) already seen, then cross overlap adds (0,5),(1,2)
      bus.ev_ready = 1'b0;
      px(1'b1, 2'b00, 8'h00);
      sb.push_back({1'b0, 3'd2});
      px(1'b0, 2'b01, 8'h04);
      idle(3);
      sb.push_back({1'b1, 3'd5});
      px(1'b0, 2'b10, 8'h20);
      idle(3);
      chk("simul_pre_count", 32'(bus.ev_count), 32'd2);
      sb.push_back({1'b0, 3'd5});
      sb.push_back({1'b1, 3'd2});
      px(1'b0, 2'b11, 8'h24);
      chk("simul_pulse", 32'(pulse), 32'h0420);
      chk("simul_count0", 32'(bus.ev_count), 32'd2);
      tick();
      chk("simul_count1", 32'(bus.ev_count), 32'd3);
      tick();
      chk("simul_count2", 32'(bus.ev_count), 32'd4);
      bus.ev_ready = 1'b1;
      idle(6);
      chk("simul_sb", 32'(sb.size()), 32'd0);
      chk("simul_drained", 32'(bus.ev_count), 32'd0);

      // backpressure with 10 pairs, then overflow and masks
      resetN = 1'b1;
      tick();
      resetN = 1'b0;
      sb.delete();
      tick();
      bus.ev_ready = 1'b0;
      px(1'b1, 2'b00, 8'h00);
      for (int b = 0; b < 2; b++)
         for (int t = 0; t < 5; t++) sb.push_back({b[0], t[2:0]});
      px(1'b0, 2'b11, 8'h1F);
      chk("bp_pulse", 32'(pulse), 32'h1F1F);
      idle(14);
      chk("bp_count", 32'(bus.ev_count), 32'd8);
      chk("bp_ovf", 32'(ovf), 32'h0);
      repeat (3) begin
         px(1'b1, 2'b00, 8'h00);
         idle(2);
      end
      px(1'b0, 2'b10, 8'h08);
      chk("ovf_pulse", 32'(pulse), 32'h0800);
      chk("ovf_set", 32'(ovf), 32'h1);
      en = 8'hFE;
      px(1'b0, 2'b01, 8'h01);
      chk("mask_en", 32'(pulse), 32'h0);
      en = 8'hFF;
      freeze = 1'b1;
      px(1'b0, 2'b01, 8'h02);
      chk("mask_freeze", 32'(pulse), 32'h0);
      freeze = 1'b0;
      idle(2);
      chk("ovf_sticky", 32'(ovf), 32'h1);
      chk("full_hold", 32'(bus.ev_count), 32'd8);
      bus.ev_ready = 1'b1;
      idle(16);
      chk("bp_sb", 32'(sb.size()), 32'd0);
      chk("bp_drained", 32'(bus.ev_count), 32'd0);
      chk("ovf_after_drain", 32'(ovf), 32'h1);

      // reset mid-frame with three events queued
      bus.ev_ready = 1'b0;
      px(1'b1, 2'b00, 8'h00);
      sb.push_back({1'b0, 3'd0});
      sb.push_back({1'b0, 3'd1});
      sb.push_back({1'b0, 3'd2});
      px(1'b0, 2'b01, 8'h07);
      idle(5);
      chk("pre_rst_count", 32'(bus.ev_count), 32'd3);
      resetN = 1'b1;
      sb.delete();
      tick();
      chk_reset_state();
      resetN = 1'b0;
      tick();
      sb.push_back({1'b0, 3'd0});
      px(1'b0, 2'b01, 8'h01);
      chk("post_rst_pulse", 32'(pulse), 32'h0001);
      bus.ev_ready = 1'b1;
      idle(5);
      chk("post_rst_sb", 32'(sb.size()), 32'd0);
      chk("post_rst_count", 32'(bus.ev_count), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
